// File: rtl/cache_bus_responder.sv
// Single-port word memory behind a simple burst read/write bus responder.
// Reads: request accepted in IDLE, fixed READ_LAT latency, then len+1 beats
// under rvalid/rready handshake. Writes: len+1 beats on wvalid with byte
// enables, followed by a one-cycle bvalid pulse.
// Optional macro BUS_RESP_BUBBLE_EN inserts LFSR-driven bubbles between read
// beats. With the macro undefined, read beats are offered back-to-back.
module cache_bus_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [3:0]  sel_i,
  input  logic        ren_i,
  input  logic [31:0] raddr_i,
  input  logic [3:0]  rlen_i,
  input  logic        rready_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [3:0]  wlen_i,
  input  logic        wvalid_i,
  input  logic [31:0] wdata_i,
  input  logic        wlast_i,
  output logic        bvalid_o
);

  typedef enum logic [2:0] {StIdle, StRlat, StRburst, StWburst, StWresp} state_e;

  localparam logic [3:0] LatLast = 4'(READ_LAT - 1);

  logic [31:0]       mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_q, beat_d;
  logic [3:0]        lat_q, lat_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bvalid_q, bvalid_d;
  logic              mem_we;
  logic              bubble;

  // Byte-address bits outside the memory and wlast_i are not needed: the
  // write burst length comes from wlen_i alone.
  logic unused_inputs;
  assign unused_inputs = ^{raddr_i[31:ADDR_W+2], raddr_i[1:0],
                           waddr_i[31:ADDR_W+2], waddr_i[1:0], wlast_i};

`ifdef BUS_RESP_BUBBLE_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; free-running
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign bubble = lfsr_q[0];
`else
  assign bubble = 1'b0;
`endif

  assign addr_inc = addr_q + 1'b1;  // wraps modulo 2^ADDR_W

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Memory write port; contents are never reset, and a reset edge blocks the write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) mem[addr_q][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    bvalid_d = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce_i) begin
          if (ren_i) begin
            addr_d  = raddr_i[ADDR_W+1:2];
            len_d   = rlen_i;
            beat_d  = '0;
            lat_d   = '0;
            state_d = StRlat;
          end else if (wen_i) begin
            addr_d  = waddr_i[ADDR_W+1:2];
            len_d   = wlen_i;
            beat_d  = '0;
            state_d = StWburst;
          end
        end
      end
      StRlat: begin
        if (lat_q == LatLast) begin
          state_d = StRburst;
          if (!bubble) begin
            rvalid_d = 1'b1;
            rdata_d  = mem[addr_q];
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRburst: begin
        if (rvalid_q && rready_i) begin
          if (beat_q == len_q) begin
            state_d  = StIdle;
            rvalid_d = 1'b0;
            rdata_d  = '0;
          end else begin
            beat_d   = beat_q + 1'b1;
            addr_d   = addr_inc;
            rvalid_d = 1'b0;
            if (!bubble) begin
              rvalid_d = 1'b1;
              rdata_d  = mem[addr_inc];
            end
          end
        end else if (!rvalid_q && !bubble) begin
          // Offer a beat withheld earlier; once offered it is held until taken
          rvalid_d = 1'b1;
          rdata_d  = mem[addr_q];
        end
      end
      StWburst: begin
        if (wvalid_i) begin
          mem_we = 1'b1;
          addr_d = addr_inc;
          if (beat_q == len_q) begin
            state_d  = StWresp;
            bvalid_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StWresp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign bvalid_o = bvalid_q;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder (default build, ADDR_W=10, READ_LAT=2).
module tb_cache_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, ren_i, rready_i, wen_i, wvalid_i, wlast_i;
  logic [3:0]  sel_i, rlen_i, wlen_i;
  logic [31:0] raddr_i, waddr_i, wdata_i, rdata_o;
  logic        rvalid_o, bvalid_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_bus_responder #(.ADDR_W(10), .READ_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (ce_i),
    .sel_i    (sel_i),
    .ren_i    (ren_i),
    .raddr_i  (raddr_i),
    .rlen_i   (rlen_i),
    .rready_i (rready_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .wen_i    (wen_i),
    .waddr_i  (waddr_i),
    .wlen_i   (wlen_i),
    .wvalid_i (wvalid_i),
    .wdata_i  (wdata_i),
    .wlast_i  (wlast_i),
    .bvalid_o (bvalid_o)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check one read beat: valid high with the given data
  task automatic chk_beat(input string tag, input logic [31:0] exp);
    chk({tag, ".rvalid"}, {31'd0, rvalid_o}, 32'd1);
    chk({tag, ".rdata"}, rdata_o, exp);
  endtask

  // Issue a read request; returns in the cycle after acceptance
  task automatic start_read(input logic [31:0] addr, input logic [3:0] len);
    ren_i = 1'b1; raddr_i = addr; rlen_i = len;
    tick();
    ren_i = 1'b0;
  endtask

  // Write burst; checks bvalid pulse after the last beat and its drop next cycle
  task automatic write_burst(input string tag, input logic [31:0] addr, input logic [3:0] len,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [3:0] s0, input logic [3:0] s1);
    wen_i = 1'b1; waddr_i = addr; wlen_i = len;
    tick();
    wen_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid_i = 1'b1;
      wdata_i  = (i == 0) ? d0 : (i == 1) ? d1 : d1 + 32'(i - 1);
      sel_i    = (i == 0) ? s0 : s1;
      wlast_i  = (i == 1);  // early wlast must not shorten the burst
      tick();
      if (i < int'(len)) chk({tag, ".bvalid_mid"}, {31'd0, bvalid_o}, 32'd0);
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    chk({tag, ".bvalid_pulse"}, {31'd0, bvalid_o}, 32'd1);
    tick();
    chk({tag, ".bvalid_drop"}, {31'd0, bvalid_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b1; sel_i = 4'hF; ren_i = 1'b0; raddr_i = '0; rlen_i = '0;
    rready_i = 1'b1; wen_i = 1'b0; waddr_i = '0; wlen_i = '0; wvalid_i = 1'b0;
    wdata_i = '0; wlast_i = 1'b0;
    tick(); tick();
    chk("reset.rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("reset.rdata", rdata_o, 32'd0);
    chk("reset.bvalid", {31'd0, bvalid_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Preload mem[4..7] = 1..4 (wlast asserted early on beat 2)
    write_burst("preload", 32'h10, 4'd3, 32'd1, 32'd2, 4'hF, 4'hF);

    // Read 4 beats straight after the write completes
    start_read(32'h10, 4'd3);
    chk("rd4.lat1", {31'd0, rvalid_o}, 32'd0);
    tick();
    chk("rd4.lat2", {31'd0, rvalid_o}, 32'd0);
    tick(); chk_beat("rd4.b0", 32'd1);
    tick(); chk_beat("rd4.b1", 32'd2);
    tick(); chk_beat("rd4.b2", 32'd3);
    tick(); chk_beat("rd4.b3", 32'd4);
    tick();
    chk("rd4.end_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rd4.end_rdata", rdata_o, 32'd0);

    // Same read with backpressure on beat 2
    start_read(32'h10, 4'd3);
    tick(); tick(); chk_beat("bp.b0", 32'd1);
    tick(); chk_beat("bp.b1", 32'd2);
    rready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_beat("bp.hold", 32'd2);
    end
    rready_i = 1'b1;
    tick(); chk_beat("bp.b2", 32'd3);
    tick(); chk_beat("bp.b3", 32'd4);
    tick();
    chk("bp.end", {31'd0, rvalid_o}, 32'd0);

    // Byte-enable write over zeroed words, then read back
    write_burst("zero", 32'h20, 4'd1, 32'd0, 32'd0, 4'hF, 4'hF);
    write_burst("bytes", 32'h20, 4'd1, 32'hAABBCCDD, 32'h11223344, 4'hF, 4'b0011);
    start_read(32'h20, 4'd1);
    tick(); tick(); chk_beat("bytes.m8", 32'hAABBCCDD);
    tick(); chk_beat("bytes.m9", 32'h00003344);
    tick();

    // Read and write together: read wins, no write happens
    ren_i = 1'b1; raddr_i = 32'h20; rlen_i = 4'd0;
    wen_i = 1'b1; waddr_i = 32'h10; wlen_i = 4'd0;
    wvalid_i = 1'b1; wdata_i = 32'hDEADBEEF; sel_i = 4'hF;
    tick();
    ren_i = 1'b0; wen_i = 1'b0;
    chk("both.bvalid0", {31'd0, bvalid_o}, 32'd0);
    tick(); chk("both.bvalid1", {31'd0, bvalid_o}, 32'd0);
    tick(); chk_beat("both.rd", 32'hAABBCCDD);
    wvalid_i = 1'b0;
    tick();
    chk("both.bvalid2", {31'd0, bvalid_o}, 32'd0);
    start_read(32'h10, 4'd0);
    tick(); tick(); chk_beat("both.unchanged", 32'd1);
    tick();

    // ce_i low: requests ignored
    ce_i = 1'b0;
    start_read(32'h10, 4'd0);
    tick(); tick(); tick();
    chk("ce0.rvalid", {31'd0, rvalid_o}, 32'd0);
    ce_i = 1'b1;
    tick();

    // Address wrap: mem[1023], then mem[0]
    write_burst("wrapw", 32'hFFC, 4'd1, 32'hCAFE0001, 32'hCAFE0002, 4'hF, 4'hF);
    start_read(32'hFFC, 4'd1);
    tick(); tick(); chk_beat("wrap.b0", 32'hCAFE0001);
    tick(); chk_beat("wrap.b1", 32'hCAFE0002);
    tick();
    chk("wrap.end", {31'd0, rvalid_o}, 32'd0);

    // Reset mid-burst aborts immediately
    start_read(32'hFFC, 4'd1);
    tick(); tick(); chk_beat("rstmid.b0", 32'hCAFE0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rstmid.rdata", rdata_o, 32'd0);
    tick();
    chk("rstmid.rvalid2", {31'd0, rvalid_o}, 32'd0);
    // Back in IDLE: a fresh request is accepted and memory survived reset
    start_read(32'h10, 4'd0);
    tick(); tick(); chk_beat("rstmid.idle_rd", 32'd1);
    tick();
    chk("rstmid.idle_end", {31'd0, rvalid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
